// File: rtl/axi_wb.sv
// FIFO-to-AXI4 write burst master: one INCR burst of len+1 32-bit beats per start.
// Define AXI_WB_BRESP_CHECK_EN to flag non-OKAY write responses on err (sticky).
module axi_wb #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            len,
  input  logic [31:0]           fifo_out_data,
  input  logic                  fifo_read_ready,
  output logic                  fifo_read_valid,
  output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic [1:0]            s_axi_awburst,
  output logic [7:0]            s_axi_awlen,
  output logic [2:0]            s_axi_awsize,
  output logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  output logic [31:0]           s_axi_wdata,
  output logic [3:0]            s_axi_wstrb,
  output logic                  s_axi_wlast,
  output logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  output logic                  s_axi_bready,
  output logic                  busy,
  output logic                  valid,
  output logic                  err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;

  logic in_addr;
  logic in_data;
  logic in_resp;
  logic in_done;
  logic w_hs;
  logic b_hs;

  // Gating with rst keeps handshakes quiet during reset itself.
  assign in_addr = (state == S_ADDR) & ~rst;
  assign in_data = (state == S_DATA) & ~rst;
  assign in_resp = (state == S_RESP) & ~rst;
  assign in_done = (state == S_DONE) & ~rst;

  assign s_axi_awvalid = in_addr;
  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = len_q;
  assign s_axi_awburst = 2'b01;
  assign s_axi_awsize  = 3'd2;

  assign s_axi_wvalid  = in_data & fifo_read_ready;
  assign s_axi_wdata   = fifo_out_data;
  assign s_axi_wstrb   = 4'hF;
  assign s_axi_wlast   = in_data & (beat_q == len_q);
  assign fifo_read_valid = s_axi_wvalid & s_axi_wready;

  assign s_axi_bready = in_resp;
  assign valid        = in_done;
  assign busy         = (state != S_IDLE) & ~rst;

  assign w_hs = fifo_read_valid;
  assign b_hs = in_resp & s_axi_bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            len_q  <= len;
            beat_q <= '0;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (s_axi_awready) state <= S_DATA;
        end
        S_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (s_axi_wlast) state <= S_RESP;
          end
        end
        S_RESP: begin
          if (s_axi_bvalid) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_WB_BRESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (b_hs && s_axi_bresp != 2'b00) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_bresp;

  assign unused_bresp = ^{s_axi_bresp, b_hs};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wb.sv
// Randomized bench for axi_wb: burst-level reference model with a FIFO queue.
// Expected err follows AXI_WB_BRESP_CHECK_EN as defined for the build.
module tb_axi_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  len;
  logic [31:0] fifo_out_data;
  logic        fifo_read_ready;
  logic        fifo_read_valid;
  logic [15:0] s_axi_awaddr;
  logic [1:0]  s_axi_awburst;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic        busy;
  logic        valid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fifo_q[$];
  logic        fifo_avail;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  axi_wb #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .len(len),
    .fifo_out_data(fifo_out_data),
    .fifo_read_ready(fifo_read_ready),
    .fifo_read_valid(fifo_read_valid),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .busy(busy), .valid(valid), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_read_ready = fifo_avail && (fifo_q.size() > 0);
    fifo_out_data   = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid"}, s_axi_awvalid, 0);
    chk({tag, "_wvalid"}, s_axi_wvalid, 0);
    chk({tag, "_wlast"}, s_axi_wlast, 0);
    chk({tag, "_bready"}, s_axi_bready, 0);
    chk({tag, "_pop"}, fifo_read_valid, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Phases: 0 idle, 1 address, 2 data, 3 response, 4 done pulse.
  task automatic run_burst(input logic [15:0] b, input logic [7:0] l,
                           input int p_aw, input int p_w,
                           input int p_b, input int p_f,
                           input int aw_delay, input int abort_after,
                           input logic [1:0] resp,
                           input bit use_words, input logic [31:0] w0);
    logic [31:0] words[$];
    int phase;
    int beats;
    int pops;
    int lasts;
    int aw_wait;
    int cyc;
    logic hs;
    words.delete();
    for (int i = 0; i <= int'(l); i++) begin
      logic [31:0] w;
      w = use_words ? (w0 + 32'(i)) : $urandom;
      words.push_back(w);
      fifo_q.push_back(w);
    end
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    len = l;
    fifo_avail = 1'b1;
    drive_fifo();
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_awvalid", s_axi_awvalid, 0);
    phase = 1; beats = 0; pops = 0; lasts = 0;
    aw_wait = 0; cyc = 0;
    while (phase != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'($urandom_range(1));
      base_addr = 16'($urandom);
      len = 8'($urandom);
      if (abort_after >= 0 && phase == 2 && beats == abort_after) begin
        rst = 1'b1;
        s_axi_awready = 1'b1;
        s_axi_wready = 1'b1;
        s_axi_bvalid = 1'b1;
        fifo_avail = 1'b1;
        drive_fifo();
        #1;
        chk_quiet("abort");
        chk("abort_err", err, 0);
        exp_err = 1'b0;
        fifo_q.delete();
        return;
      end
      s_axi_awready = (aw_wait >= aw_delay) &&
                      ($urandom_range(99) < p_aw);
      s_axi_wready = $urandom_range(99) < p_w;
      s_axi_bvalid = $urandom_range(99) < p_b;
      s_axi_bresp = resp;
      fifo_avail = $urandom_range(99) < p_f;
      drive_fifo();
      #1;
      chk("err", err, exp_err);
      pops += int'(fifo_read_valid);
      case (phase)
        1: begin
          chk("aw_valid", s_axi_awvalid, 1);
          chk("aw_addr", s_axi_awaddr, b);
          chk("aw_len", s_axi_awlen, l);
          chk("aw_burst", s_axi_awburst, 1);
          chk("aw_size", s_axi_awsize, 2);
          chk("aw_wvalid", s_axi_wvalid, 0);
          chk("aw_pop", fifo_read_valid, 0);
          chk("aw_bready", s_axi_bready, 0);
          chk("aw_busy", busy, 1);
          aw_wait++;
          if (s_axi_awready) phase = 2;
        end
        2: begin
          hs = fifo_read_ready & s_axi_wready;
          chk("w_awvalid", s_axi_awvalid, 0);
          chk("w_wvalid", s_axi_wvalid, fifo_read_ready);
          chk("w_wlast", s_axi_wlast, beats == int'(l));
          chk("w_pop", fifo_read_valid, hs);
          chk("w_bready", s_axi_bready, 0);
          chk("w_valid", valid, 0);
          if (fifo_read_ready) begin
            chk("w_data", s_axi_wdata, words[beats]);
            chk("w_strb", s_axi_wstrb, 4'hF);
          end
          if (hs) begin
            lasts += int'(s_axi_wlast);
            void'(fifo_q.pop_front());
            if (beats == int'(l)) phase = 3;
            beats++;
          end
        end
        3: begin
          chk("b_bready", s_axi_bready, 1);
          chk("b_awvalid", s_axi_awvalid, 0);
          chk("b_wvalid", s_axi_wvalid, 0);
          chk("b_pop", fifo_read_valid, 0);
          chk("b_valid", valid, 0);
          if (s_axi_bvalid) begin
`ifdef AXI_WB_BRESP_CHECK_EN
            if (resp != 2'b00) exp_err = 1'b1;
`endif
            phase = 4;
          end
        end
        default: begin
          chk("done_valid", valid, 1);
          chk("done_busy", busy, 1);
          chk("done_bready", s_axi_bready, 0);
          phase = 0;
        end
      endcase
    end
    if (phase != 0) chk("timeout", 1, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk_quiet("post");
    chk("beats", beats, int'(l) + 1);
    chk("pops", pops, int'(l) + 1);
    chk("wlast_count", lasts, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    fifo_avail = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp = 2'b00;
    drive_fifo();
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_err", err, 0);
    chk("reset_awaddr", s_axi_awaddr, 0);
    chk("reset_awlen", s_axi_awlen, 0);
    @(negedge clk);
    rst = 1'b0;

    run_burst(16'h0100, 8'd3, 100, 100, 100, 100, 0, -1, 2'b00, 1'b1, 32'hA0);
    run_burst(16'h0200, 8'd0, 100, 100, 100, 100, 0, -1, 2'b00, 1'b1, 32'h55);
    run_burst(16'h0300, 8'd2, 100, 100, 100, 100, 5, -1, 2'b00, 1'b0, 32'h0);
    run_burst(16'h0400, 8'd7, 100, 50, 100, 40, 0, -1, 2'b00, 1'b0, 32'h0);

    run_burst(16'h0500, 8'd3, 100, 100, 100, 100, 0, 2, 2'b00, 1'b1, 32'hB0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("wait_start_busy", busy, 0);
    end
    run_burst(16'h0600, 8'd1, 100, 100, 100, 100, 0, -1, 2'b00, 1'b0, 32'h0);

    run_burst(16'h0700, 8'd1, 100, 100, 100, 100, 0, -1, 2'b10, 1'b0, 32'h0);
    run_burst(16'h0800, 8'd2, 100, 100, 100, 100, 0, -1, 2'b00, 1'b0, 32'h0);
    run_burst(16'hFFFC, 8'd255, 100, 100, 100, 100, 0, -1, 2'b00, 1'b0, 32'h0);

    for (int k = 0; k < 25; k++) begin
      run_burst(16'($urandom), 8'($urandom_range(20)),
                $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(3), -1, 2'b00, 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
